// File: rtl/mc_control.sv
// mc_control: multicycle LEGv8 Moore control FSM driving datapath selects and strobes.
module mc_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] Op,
  input  logic        Zero,
  input  logic        condTrue,
  input  logic        mem_ready,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSrc,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        FlagWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
    S_ALUWB = 4'd4, S_MEMADR = 4'd5, S_MEMRD = 4'd6, S_MEMWB = 4'd7,
    S_MEMWR = 4'd8, S_CBZ = 4'd9, S_BCOND = 4'd10, S_HALT = 4'd15
  } state_t;
  state_t r_state, w_next;
  logic r_illegal;
  logic w_ldur, w_stur, w_rfmt, w_ifmt, w_cbz, w_bcond, w_rflag;
  logic w_mem_read, w_mem_write, w_ir_write, w_pc_write, w_pc_write_cond;
  logic w_reg_write, w_flag_write, w_done;
  logic w_unused_zero;
  // Zero qualifies PCWriteCond inside the datapath, not here
  assign w_unused_zero = Zero;
  assign w_ldur  = Op == 11'b11111000010;
  assign w_stur  = Op == 11'b11111000000;
  assign w_rfmt  = Op inside {11'b10001011000, 11'b11001011000, 11'b10101011000,
                              11'b11101011000, 11'b10001010000, 11'b10101010000};
  assign w_rflag = Op inside {11'b10101011000, 11'b11101011000};
  assign w_ifmt  = Op ==? 11'b1??1000100?;
  assign w_cbz   = Op ==? 11'b10110100???;
  assign w_bcond = Op ==? 11'b01010100???;
  assign Reg2Loc = w_stur | w_cbz;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | (w_next == S_HALT);
    end
  always_comb begin
    w_next = r_state;
    IorD = 1'b0;
    PCSrc = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    w_mem_read = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write = 1'b0;
    w_pc_write = 1'b0;
    w_pc_write_cond = 1'b0;
    w_reg_write = 1'b0;
    w_flag_write = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        ALUSrcB = 2'b01;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        w_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        w_next = (w_ldur | w_stur) ? S_MEMADR :
                 w_rfmt  ? S_EXEC_R :
                 w_ifmt  ? S_EXEC_I :
                 w_cbz   ? S_CBZ :
                 w_bcond ? S_BCOND : S_HALT;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        w_flag_write = w_rflag;
        w_next = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp = 2'b10;
        w_flag_write = Op[8];
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_done = 1'b1;
        w_next = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next = w_ldur ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD = 1'b1;
        w_mem_read = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        MemtoReg = 1'b1;
        w_done = 1'b1;
        w_next = S_FETCH;
      end
      S_MEMWR: begin
        IorD = 1'b1;
        w_mem_write = 1'b1;
        w_done = mem_ready;
        w_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_CBZ: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        w_pc_write_cond = 1'b1;
        PCSrc = 1'b1;
        w_done = 1'b1;
        w_next = S_FETCH;
      end
      S_BCOND: begin
        w_pc_write = condTrue;
        PCSrc = 1'b1;
        w_done = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end
  // strobes are masked by reset so nothing writes while reset_n is held low
  assign MemRead     = w_mem_read & reset_n;
  assign MemWrite    = w_mem_write & reset_n;
  assign IRWrite     = w_ir_write & reset_n;
  assign PCWrite     = w_pc_write & reset_n;
  assign PCWriteCond = w_pc_write_cond & reset_n;
  assign RegWrite    = w_reg_write & reset_n;
  assign FlagWrite   = w_flag_write & reset_n;
  assign instr_done  = w_done & reset_n;
  assign illegal     = r_illegal;
  assign state       = r_state;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed-vector bench for mc_control with hand-computed expectations.
module tb_mc_control;
  logic clk = 1'b0;
  logic reset_n, Zero, condTrue, mem_ready;
  logic [10:0] Op;
  logic IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSrc, Reg2Loc;
  logic RegWrite, MemtoReg, FlagWrite, ALUSrcA, instr_done, illegal;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] state;
  logic [7:0] strb, sel;
  int n_chk = 0;
  int n_bad = 0;
  mc_control dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Zero(Zero), .condTrue(condTrue),
    .mem_ready(mem_ready), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc),
    .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .FlagWrite(FlagWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  assign strb = {MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite, FlagWrite, instr_done};
  assign sel  = {IorD, PCSrc, ALUSrcA, ALUSrcB, ALUOp, MemtoReg};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic exp_st(input string tag, input logic [3:0] st, input logic [7:0] sb, input logic [7:0] sl);
    #1;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".strb"}, 32'(strb), 32'(sb));
    check({tag, ".sel"}, 32'(sel), 32'(sl));
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; Op = 11'b10101011000; Zero = 1'b0; condTrue = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_st("rst", 4'd0, 8'h00, 8'h08);
    check("rst.illegal", 32'(illegal), 32'd0);
    reset_n = 1'b1;
    exp_st("adds.f", 4'd0, 8'hB0, 8'h08);
    cyc; exp_st("adds.d", 4'd1, 8'h00, 8'h18);
    cyc; exp_st("adds.x", 4'd2, 8'h02, 8'h24);
    check("adds.r2l", 32'(Reg2Loc), 32'd0);
    cyc; exp_st("adds.wb", 4'd4, 8'h05, 8'h00);
    cyc; Op = 11'b11111000010;
    exp_st("ld.f", 4'd0, 8'hB0, 8'h08);
    cyc; exp_st("ld.d", 4'd1, 8'h00, 8'h18);
    cyc; mem_ready = 1'b0;
    exp_st("ld.ma", 4'd5, 8'h00, 8'h30);
    cyc; exp_st("ld.r0", 4'd6, 8'h80, 8'h80);
    cyc; exp_st("ld.r1", 4'd6, 8'h80, 8'h80);
    cyc; mem_ready = 1'b1;
    exp_st("ld.r2", 4'd6, 8'h80, 8'h80);
    cyc; exp_st("ld.wb", 4'd7, 8'h05, 8'h01);
    cyc; Op = 11'b11110001001; mem_ready = 1'b0;
    exp_st("fw.0", 4'd0, 8'h80, 8'h08);
    cyc; exp_st("fw.1", 4'd0, 8'h80, 8'h08);
    mem_ready = 1'b1;
    exp_st("subis.f", 4'd0, 8'hB0, 8'h08);
    cyc; exp_st("subis.d", 4'd1, 8'h00, 8'h18);
    cyc; exp_st("subis.x", 4'd3, 8'h02, 8'h34);
    cyc; exp_st("subis.wb", 4'd4, 8'h05, 8'h00);
    cyc; Op = 11'b10110100101;
    for (int z = 1; z >= 0; z--) begin
      Zero = z[0];
      exp_st("cbz.f", 4'd0, 8'hB0, 8'h08);
      check("cbz.f.r2l", 32'(Reg2Loc), 32'd1);
      cyc; exp_st("cbz.d", 4'd1, 8'h00, 8'h18);
      check("cbz.d.r2l", 32'(Reg2Loc), 32'd1);
      cyc; exp_st("cbz.x", 4'd9, 8'h09, 8'h62);
      check("cbz.x.r2l", 32'(Reg2Loc), 32'd1);
      cyc;
    end
    Op = 11'b01010100000;
    for (int c = 0; c < 2; c++) begin
      condTrue = c[0];
      exp_st("bc.f", 4'd0, 8'hB0, 8'h08);
      cyc; exp_st("bc.d", 4'd1, 8'h00, 8'h18);
      cyc; exp_st("bc.x", 4'd10, (c == 1) ? 8'h11 : 8'h01, 8'h40);
      cyc;
    end
    Op = 11'b00000000000;
    exp_st("ill.f", 4'd0, 8'hB0, 8'h08);
    cyc; exp_st("ill.d", 4'd1, 8'h00, 8'h18);
    cyc; exp_st("ill.h0", 4'd15, 8'h00, 8'h00);
    check("ill.flag0", 32'(illegal), 32'd1);
    cyc; mem_ready = 1'b0;
    cyc; exp_st("ill.h1", 4'd15, 8'h00, 8'h00);
    check("ill.flag1", 32'(illegal), 32'd1);
    reset_n = 1'b0; mem_ready = 1'b1;
    exp_st("rst2", 4'd0, 8'h00, 8'h08);
    check("rst2.illegal", 32'(illegal), 32'd0);
    cyc; reset_n = 1'b1; Op = 11'b11111000000;
    exp_st("st.f", 4'd0, 8'hB0, 8'h08);
    check("st.r2l", 32'(Reg2Loc), 32'd1);
    cyc; exp_st("st.d", 4'd1, 8'h00, 8'h18);
    cyc; exp_st("st.ma", 4'd5, 8'h00, 8'h30);
    cyc; mem_ready = 1'b0;
    exp_st("st.w0", 4'd8, 8'h40, 8'h80);
    mem_ready = 1'b1;
    exp_st("st.w1", 4'd8, 8'h41, 8'h80);
    reset_n = 1'b0;
    exp_st("st.abort", 4'd0, 8'h00, 8'h08);
    repeat (2) cyc;
    reset_n = 1'b1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_control.md
# mc_control

Multicycle LEGv8 control unit that sequences a shared-ALU, shared-memory datapath one instruction at a time. It sits beside the datapath in the multicycle processor variant. It decodes the registered opcode, walks a Moore state machine through fetch, decode, execute, memory and write-back, and drives every mux select and write strobe. A ready handshake stretches memory states for wait-state memories.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- Op  in  11  instruction register bits [31:21].
- Zero  in  1  ALU zero flag, combinational, same cycle.
- condTrue  in  1  B.cond evaluation against stored NZCV, combinational.
- mem_ready  in  1  memory completes the current access this cycle.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1  memory strobes.
- IRWrite, PCWrite, PCWriteCond  out  1  IR load, unconditional PC load, PC load qualified by Zero.
- PCSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- Reg2Loc  out  1  1 when Op is STUR or CBZ, in every state. Purely combinational from Op.
- RegWrite, MemtoReg, FlagWrite  out  1  register-file write, write-back source (1 = MDR), NZCV load.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = branch offset << 2.
- ALUOp  out  2  00 = add, 01 = pass B, 10 = funct decode.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal  out  1  sticky; set on an unknown opcode.
- state  out  4  current state encoding, for debug.

## Operation
States, with outputs not listed held at 0:
- FETCH (0): IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00, so the branch target is latched in ALUOut. Next state by Op:
  - LDUR 11111000010 or STUR 11111000000 -> MEMADR.
  - R-format (ADD, SUB, ADDS, SUBS, AND, ORR) -> EXEC_R.
  - I-format (ADDI, SUBI, ADDIS, SUBIS; Op[0] is don't-care) -> EXEC_I.
  - CBZ 10110100xxx -> CBZ.
  - B.cond 01010100xxx -> BCOND.
  - Anything else -> HALT.
- EXEC_R (2): ALUSrcA=1, ALUSrcB=00, ALUOp=10. FlagWrite=1 for ADDS/SUBS. Next: ALUWB.
- EXEC_I (3): ALUSrcA=1, ALUSrcB=10, ALUOp=10. FlagWrite=1 for ADDIS/SUBIS. Next: ALUWB.
- ALUWB (4): RegWrite=1, MemtoReg=0, instr_done=1. Next: FETCH.
- MEMADR (5): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD for LDUR, MEMWR for STUR.
- MEMRD (6): IorD=1, MemRead=1. Waits for mem_ready, then MEMWB.
- MEMWB (7): RegWrite=1, MemtoReg=1, instr_done=1. Next: FETCH.
- MEMWR (8): IorD=1, MemWrite=1, instr_done=mem_ready. Waits for mem_ready, then FETCH.
- CBZ (9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=1, instr_done=1. Next: FETCH.
- BCOND (10): PCWrite=condTrue, PCSrc=1, instr_done=1. Next: FETCH.
- HALT (15): all strobes 0, illegal=1. Leaves HALT only on reset.

Rules:
- Strobes are a Moore function of state and Op. mem_ready gates only the listed strobes and transitions.
- Op is sampled every cycle, not latched. The IR is stable from DECODE onward.
- Unused encodings 11–14 go to HALT.

## Timing
- Reset (reset_n low, asynchronous):
  - state=FETCH, illegal=0.
  - All strobes (MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite, FlagWrite, instr_done) forced to 0 while reset_n is low.
  - Selects take their FETCH values.
- First fetch begins in the first cycle after reset_n rises.
- Reset asserted mid-instruction aborts it at once; no partial write strobe is issued after assertion.
- Latency with mem_ready tied to 1:
  - R-format and I-format: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ and B.cond: 3 cycles.
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- mem_ready is ignored outside those three states.

## Test plan
- Reset: hold reset_n=0 with mem_ready=1 -> state=0, all strobes 0, illegal=0. First IRWrite/PCWrite pulse appears in the cycle after release.
- ADDS (Op=10101011000), mem_ready=1 -> states 0,1,2,4. FlagWrite=1 in EXEC_R. RegWrite=1 and instr_done=1 in cycle 4.
- LDUR with mem_ready low for 2 cycles in MEMRD -> states 0,1,5,6,6,6,7. MemRead held for 3 cycles. 7 cycles total.
- CBZ (Op=10110100101) with Zero=1, then again with Zero=0 -> PCWriteCond=1 and PCSrc=1 in state 9 in both runs. Reg2Loc=1 in every state of both runs.
- B.cond (Op=01010100000) with condTrue=0 -> PCWrite=0 in BCOND, return to FETCH after 3 cycles.
- Op=00000000000 -> DECODE then HALT. illegal=1 and no strobes until reset. Then pulse reset_n low mid-STUR MEMWR -> MemWrite drops immediately and state=0.
